// File: rtl/ysyx_25020047_mem_responder_if.sv
// ysyx_25020047_mem_responder_if
//   Load/store bus between the LSU (master) and the memory responder (slave).
//   Read channel : arvalid/arready/araddr request, rvalid/rready/rdata/rresp response.
//   Write channel: awvalid/awready/awaddr/wdata/wstrb request (address, data and
//                  byte strobes travel together), bvalid/bready/bresp response.
//   Responses use 2'b00 for OKAY and 2'b10 for SLVERR.
interface ysyx_25020047_mem_responder_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_25020047_mem_responder.sv
// ysyx_25020047_mem_responder
//   Memory-side responder for LSU load/store requests. Accepts one word read or
//   byte-masked write at a time, waits a programmable latency, performs the access
//   on the physical-memory port, then holds the response until the LSU takes it.
// Ports
//   clock       in   system clock, all state on rising edge
//   reset       in   asynchronous active-high reset
//   bus         slave side of the load/store bus interface
//   pmem_ren    out  single-cycle read strobe; pmem_rdata is captured on that edge
//   pmem_wen    out  single-cycle write strobe; exactly one per performed write
//   pmem_addr   out  word-aligned access address
//   pmem_wdata  out  write data (already lane-shifted by the LSU)
//   pmem_wmask  out  byte-lane enables for the write
//   pmem_rdata  in   word read from memory at pmem_addr
module ysyx_25020047_mem_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE  = 32'h0800_0000,
  parameter int          LATENCY   = 1,
  parameter int          LAT_W     = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  ysyx_25020047_mem_responder_if.slave bus,
  output logic                         pmem_ren,
  output logic                         pmem_wen,
  output logic [31:0]                  pmem_addr,
  output logic [31:0]                  pmem_wdata,
  output logic [3:0]                   pmem_wmask,
  input  logic [31:0]                  pmem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // The wait state itself already takes one cycle, so the counter is loaded one
  // short; the response then first shows LATENCY+1 cycles after the accept cycle.
  // LATENCY of 0 behaves like 1 because one wait cycle is the minimum.
  localparam logic [LAT_W-1:0] LAT_LOAD = (LATENCY == 0) ? '0 : LAT_W'(LATENCY - 1);

  // 33-bit bounds so ADDR_BASE+MEM_SIZE can reach 2^32 without wrapping.
  localparam logic [32:0] BASE33  = {1'b0, ADDR_BASE};
  localparam logic [32:0] LIMIT33 = {1'b0, ADDR_BASE} + {1'b0, MEM_SIZE};

  state_t           state;
  logic [LAT_W-1:0] counter;
  logic             prio;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             rvalid_q;
  logic             bvalid_q;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q;
  logic [1:0]       bresp_q;

  logic grant_rd;
  logic grant_wr;
  logic in_range;
  logic access_now;

  // Arbitration: a lone request always wins; when both are pending, prio picks
  // the channel (0 = read) and is flipped after each grant so they alternate.
  assign grant_rd = (state == IDLE) && bus.arvalid && (!bus.awvalid || !prio);
  assign grant_wr = (state == IDLE) && bus.awvalid && (!bus.arvalid || prio);

  assign in_range   = ({1'b0, addr_q} >= BASE33) && ({1'b0, addr_q} < LIMIT33);
  assign access_now = (counter == '0);

  assign pmem_addr  = {addr_q[31:2], 2'b00};
  assign pmem_wdata = wdata_q;
  assign pmem_wmask = wstrb_q;
  assign pmem_ren   = (state == RD_WAIT) && access_now && in_range;
  assign pmem_wen   = (state == WR_WAIT) && access_now && in_range && (wstrb_q != 4'b0000);

  assign bus.arready = grant_rd;
  assign bus.awready = grant_wr;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;

  // Transaction FSM: accept, count down, access on the final wait edge, then
  // hold the response until the initiator's ready is sampled high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      prio     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (grant_rd) begin
            addr_q  <= bus.araddr;
            counter <= LAT_LOAD;
            prio    <= 1'b1;
            state   <= RD_WAIT;
          end else if (grant_wr) begin
            addr_q  <= bus.awaddr;
            wdata_q <= bus.wdata;
            wstrb_q <= bus.wstrb;
            counter <= LAT_LOAD;
            prio    <= 1'b0;
            state   <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (!access_now) begin
            counter <= counter - 1'b1;
          end else begin
            rdata_q  <= in_range ? pmem_rdata : 32'h0;
            rresp_q  <= in_range ? RESP_OKAY : RESP_SLVERR;
            rvalid_q <= 1'b1;
            state    <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (bus.rready) begin
            rvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        WR_WAIT: begin
          if (!access_now) begin
            counter <= counter - 1'b1;
          end else begin
            bresp_q  <= in_range ? RESP_OKAY : RESP_SLVERR;
            bvalid_q <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.bready) begin
            bvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_mem_responder.sv
// tb_ysyx_25020047_mem_responder
//   Self-checking bench: a LATENCY=1 responder drives most traffic through a
//   vector table; a LATENCY=4 responder is used for reset during a pending write.
//   Both share a small word memory model covering 0x8000_0000..0x8000_00FF.
module tb_ysyx_25020047_mem_responder;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  ysyx_25020047_mem_responder_if bus1 ();
  ysyx_25020047_mem_responder_if bus2 ();

  logic        p1_ren, p1_wen, p2_ren, p2_wen;
  logic [31:0] p1_addr, p1_wdata, p1_rdata, p2_addr, p2_wdata, p2_rdata;
  logic [3:0]  p1_wmask, p2_wmask;

  ysyx_25020047_mem_responder #(.LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1),
    .pmem_ren(p1_ren), .pmem_wen(p1_wen), .pmem_addr(p1_addr),
    .pmem_wdata(p1_wdata), .pmem_wmask(p1_wmask), .pmem_rdata(p1_rdata)
  );

  ysyx_25020047_mem_responder #(.LATENCY(4)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2),
    .pmem_ren(p2_ren), .pmem_wen(p2_wen), .pmem_addr(p2_addr),
    .pmem_wdata(p2_wdata), .pmem_wmask(p2_wmask), .pmem_rdata(p2_rdata)
  );

  logic [31:0] mem [0:63] = '{default: 32'h0};
  int wr_count = 0;

  assign p1_rdata = mem[p1_addr[7:2]];
  assign p2_rdata = mem[p2_addr[7:2]];

  // Memory model: byte-masked writes land on the strobe edge; every strobe is counted.
  always @(posedge clock) begin
    if (p1_wen)
      for (int b = 0; b < 4; b++)
        if (p1_wmask[b]) mem[p1_addr[7:2]][8*b +: 8] <= p1_wdata[8*b +: 8];
    if (p2_wen)
      for (int b = 0; b < 4; b++)
        if (p2_wmask[b]) mem[p2_addr[7:2]][8*b +: 8] <= p2_wdata[8*b +: 8];
    wr_count <= wr_count + int'(p1_wen) + int'(p2_wen);
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_wr;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idleMasters();
    bus1.arvalid = 1'b0; bus1.araddr = '0; bus1.rready = 1'b0;
    bus1.awvalid = 1'b0; bus1.awaddr = '0; bus1.wdata = '0; bus1.wstrb = '0; bus1.bready = 1'b0;
    bus2.arvalid = 1'b0; bus2.araddr = '0; bus2.rready = 1'b0;
    bus2.awvalid = 1'b0; bus2.awaddr = '0; bus2.wdata = '0; bus2.wstrb = '0; bus2.bready = 1'b0;
  endtask

  // Waits (bounded) for the selected response valid on bus1 at negedges, returns cycles seen.
  task automatic waitResp1(input bit is_wr, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(is_wr ? bus1.bvalid : bus1.rvalid) && n < 20);
  endtask

  // Takes the held response on bus1 (we are at a negedge) and checks valid drops.
  task automatic takeResp1(input bit is_wr, input string tag);
    if (is_wr) bus1.bready = 1'b1; else bus1.rready = 1'b1;
    @(posedge clock); #1;
    bus1.bready = 1'b0; bus1.rready = 1'b0;
    @(negedge clock);
    checkOutput({tag, "_valid_drop"}, is_wr ? 32'(bus1.bvalid) : 32'(bus1.rvalid), 32'h0);
  endtask

  // One full transaction on the LATENCY=1 responder with latency/response checks.
  task automatic applyStimulus(input vec_t v, input string tag);
    int n;
    int wr_before;
    wr_before = wr_count;
    @(posedge clock); #1;
    if (v.is_wr) begin
      bus1.awvalid = 1'b1; bus1.awaddr = v.addr; bus1.wdata = v.wdata; bus1.wstrb = v.wstrb;
    end else begin
      bus1.arvalid = 1'b1; bus1.araddr = v.addr;
    end
    @(negedge clock);
    checkOutput({tag, "_ready"}, v.is_wr ? 32'(bus1.awready) : 32'(bus1.arready), 32'h1);
    @(posedge clock); #1;
    bus1.awvalid = 1'b0; bus1.arvalid = 1'b0;
    waitResp1(v.is_wr, n);
    checkOutput({tag, "_latency"}, 32'(n), 32'd2);
    if (v.is_wr) begin
      checkOutput({tag, "_bresp"}, 32'(bus1.bresp), 32'(v.exp_resp));
    end else begin
      checkOutput({tag, "_rresp"}, 32'(bus1.rresp), 32'(v.exp_resp));
      checkOutput({tag, "_rdata"}, bus1.rdata, v.exp_rdata);
    end
    takeResp1(v.is_wr, tag);
    checkOutput({tag, "_writes"}, 32'(wr_count - wr_before), 32'(v.exp_wr));
  endtask

  // Raises both request channels and checks which one the arbiter grants.
  task automatic bothRequest(input bit expect_read, input string tag);
    int n;
    @(posedge clock); #1;
    bus1.arvalid = 1'b1; bus1.araddr = 32'h8000_0000;
    bus1.awvalid = 1'b1; bus1.awaddr = 32'h8000_0008; bus1.wdata = 32'h0BAD_CAFE; bus1.wstrb = 4'hF;
    @(negedge clock);
    checkOutput({tag, "_arready"}, 32'(bus1.arready), 32'(expect_read));
    checkOutput({tag, "_awready"}, 32'(bus1.awready), 32'(!expect_read));
    @(posedge clock); #1;
    bus1.arvalid = 1'b0; bus1.awvalid = 1'b0;
    waitResp1(!expect_read, n);
    checkOutput({tag, "_resp_seen"}, 32'(n < 20), 32'h1);
    if (expect_read) checkOutput({tag, "_rdata"}, bus1.rdata, 32'hDEAD_BEEF);
    takeResp1(!expect_read, tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int wr_before;
    logic [31:0] held;

    vecs[0]  = '{1'b1, 32'h8000_0000, 32'h1122_3344, 4'hF, 32'h0,         2'b00, 1};
    vecs[1]  = '{1'b1, 32'h8000_0002, 32'h00AB_0000, 4'h4, 32'h0,         2'b00, 1};
    vecs[2]  = '{1'b0, 32'h8000_0003, 32'h0,         4'h0, 32'h11AB_3344, 2'b00, 0};
    vecs[3]  = '{1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00, 1};
    vecs[4]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00, 0};
    vecs[5]  = '{1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'h0, 32'h0,         2'b00, 0};
    vecs[6]  = '{1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'h0,         2'b00, 0};
    vecs[7]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b10, 0};
    vecs[8]  = '{1'b1, 32'h8800_0000, 32'h1234_5678, 4'hF, 32'h0,         2'b10, 0};
    vecs[9]  = '{1'b0, 32'h87FF_FFFC, 32'h0,         4'h0, 32'h0,         2'b00, 0};
    vecs[10] = '{1'b0, 32'h8800_0000, 32'h0,         4'h0, 32'h0,         2'b10, 0};
    vecs[11] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00, 0};

    idleMasters();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_arready", 32'(bus1.arready), 32'h0);
    checkOutput("reset_awready", 32'(bus1.awready), 32'h0);
    checkOutput("reset_rvalid",  32'(bus1.rvalid),  32'h0);
    checkOutput("reset_bvalid",  32'(bus1.bvalid),  32'h0);
    checkOutput("reset_rdata",   bus1.rdata,        32'h0);
    checkOutput("reset_rresp",   32'(bus1.rresp),   32'h0);
    checkOutput("reset_bresp",   32'(bus1.bresp),   32'h0);

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Arbitration alternates starting from read after reset.
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    bothRequest(1'b1, "both1");
    bothRequest(1'b0, "both2");
    bothRequest(1'b1, "both3");
    checkOutput("both_mem_word2", mem[2], 32'h0BAD_CAFE);

    // Back-pressure: response must hold while rready is low, no new accept meanwhile.
    @(posedge clock); #1;
    bus1.arvalid = 1'b1; bus1.araddr = 32'h8000_0000;
    @(posedge clock); #1;
    waitResp1(1'b0, n);
    checkOutput("bp_resp_seen", 32'(n < 20), 32'h1);
    held = bus1.rdata;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checkOutput($sformatf("bp_rvalid_c%0d", c),  32'(bus1.rvalid),  32'h1);
      checkOutput($sformatf("bp_rdata_c%0d", c),   bus1.rdata,        32'hDEAD_BEEF);
      checkOutput($sformatf("bp_rresp_c%0d", c),   32'(bus1.rresp),   32'h0);
      checkOutput($sformatf("bp_arready_c%0d", c), 32'(bus1.arready), 32'h0);
    end
    @(posedge clock); #1 bus1.rready = 1'b1;
    @(negedge clock);
    checkOutput("bp_arready_hs", 32'(bus1.arready), 32'h0);
    @(posedge clock); #1 bus1.rready = 1'b0;
    @(negedge clock);
    checkOutput("bp_rvalid_after", 32'(bus1.rvalid),  32'h0);
    checkOutput("bp_rdata_kept",   bus1.rdata,        held);
    checkOutput("bp_arready_next", 32'(bus1.arready), 32'h1);
    @(posedge clock); #1 bus1.arvalid = 1'b0;
    waitResp1(1'b0, n);
    checkOutput("bp2_rdata", bus1.rdata, 32'hDEAD_BEEF);
    takeResp1(1'b0, "bp2");

    // Reset while the LATENCY=4 responder is still waiting to write.
    wr_before = wr_count;
    @(posedge clock); #1;
    bus2.awvalid = 1'b1; bus2.awaddr = 32'h8000_0000; bus2.wdata = 32'hCAFE_F00D; bus2.wstrb = 4'hF;
    @(negedge clock);
    checkOutput("rst_wait_awready", 32'(bus2.awready), 32'h1);
    @(posedge clock); #1 bus2.awvalid = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    #1;
    checkOutput("rst_wait_bvalid",  32'(bus2.bvalid),  32'h0);
    checkOutput("rst_wait_rvalid",  32'(bus2.rvalid),  32'h0);
    checkOutput("rst_wait_bresp",   32'(bus2.bresp),   32'h0);
    checkOutput("rst_wait_rdata",   bus2.rdata,        32'h0);
    checkOutput("rst_wait_awready", 32'(bus2.awready), 32'h0);
    @(posedge clock); #1 reset = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    checkOutput("rst_wait_bvalid_later", 32'(bus2.bvalid), 32'h0);
    checkOutput("rst_wait_writes", 32'(wr_count - wr_before), 32'h0);
    applyStimulus(vecs[11], "rst_readback");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
